// File: rtl/rcb_drape_pkg.sv
// Shared state encoding, fault codes and timer width for the drape EM sequencer.
package rcb_drape_pkg;

  localparam int US_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENERGIZE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_NO_CONFIRM = 2'b01,
    FC_NO_RELEASE = 2'b10,
    FC_UNEXPECTED = 2'b11
  } fault_code_e;

endpackage

// File: rtl/us_timer.sv
// Microsecond down-counter: TICK_DIV-cycle prescaler plus a us counter loaded on restart.
// expire_o marks the last cycle of a loaded interval, so N us spans exactly N*TICK_DIV cycles.
module us_timer
  import rcb_drape_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            restart_i,
  input  logic [US_W-1:0] load_us_i,
  output logic            expire_o
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]   psc_q, psc_d;
  logic [US_W-1:0] us_q, us_d;
  logic            tick;

  assign tick     = (psc_q == '0);
  assign expire_o = tick && (us_q == US_W'(1));

  always_comb begin
    psc_d = psc_q;
    us_d  = us_q;
    if (restart_i) begin
      psc_d = PSC_MAX;
      us_d  = load_us_i;
    end else if (us_q != '0) begin
      if (tick) begin
        psc_d = PSC_MAX;
        us_d  = us_q - US_W'(1);
      end else begin
        psc_d = psc_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q <= '0;
      us_q  <= '0;
    end else begin
      psc_q <= psc_d;
      us_q  <= us_d;
    end
  end

endmodule

// File: rtl/drape_em_sequencer.sv
// Grants one drape electromagnet at a time: energize until confirmed, hold, then cool down.
// state | meaning: IDLE wait for request | ENERGIZE drive, await em_state | HOLD timed drive | COOLDOWN off-time | FAULT sticky
module drape_em_sequencer
  import rcb_drape_pkg::*;
#(
  parameter int TICK_DIV   = 100,
  parameter int CONFIRM_US = 100000,
  parameter int HOLD_US    = 500000,
  parameter int COOL_US    = 200000
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       req_right,
  input  logic       req_left,
  input  logic       abort,
  input  logic       fault_clr,
  input  logic       right_drape_em_state,
  input  logic       left_drape_em_state,
  output logic       right_drape_em_open,
  output logic       left_drape_em_open,
  output logic       busy,
  output logic       grant_right,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  // Two-bit side vectors throughout: bit 1 = right, bit 0 = left.
  state_e          state_q, state_d;
  fault_code_e     code_q, code_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      open_q, unexp_q, unexp_now;
  logic [1:0]      em_state, req_vec, grant_mask, serving, cool_exempt;
  logic            grant_q, grant_d;
  logic            aborted_q, aborted_d;
  logic            busy_q, done_q, done_d, fault_q;
  logic            em_granted, unexpected, expire, restart;
  logic [US_W-1:0] load_us;

  assign em_state   = {right_drape_em_state, left_drape_em_state};
  assign req_vec    = {req_right, req_left};
  assign grant_mask = grant_q ? 2'b10 : 2'b01;
  assign em_granted = |(em_state & grant_mask);
  assign serving    = (state_q == ST_ENERGIZE || state_q == ST_HOLD || state_q == ST_COOLDOWN)
                      ? grant_mask : 2'b00;

  // The granted magnet is expected to still be releasing during cooldown; a stuck one is
  // reported as NO_RELEASE at expiry rather than UNEXPECTED.
  assign cool_exempt = (state_q == ST_COOLDOWN) ? grant_mask : 2'b00;
  assign unexp_now   = em_state & ~open_q & ~cool_exempt & {2{state_q != ST_FAULT}};
  assign unexpected  = |(unexp_now & unexp_q);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pend_d    = pend_q | (req_vec & ~serving);
    grant_d   = grant_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && pend_q != 2'b00) begin
          grant_d   = (pend_q == 2'b11) ? ~grant_q : pend_q[1];
          pend_d    = pend_d & ~(grant_d ? 2'b10 : 2'b01);
          aborted_d = 1'b0;
          state_d   = ST_ENERGIZE;
        end
      end
      ST_ENERGIZE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_COOLDOWN;
        end else if (em_granted) begin
          state_d = ST_HOLD;
        end else if (expire) begin
          code_d  = FC_NO_CONFIRM;
          state_d = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_COOLDOWN;
        end else if (expire) begin
          state_d = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (expire) begin
          if (em_granted) begin
            code_d  = FC_NO_RELEASE;
            state_d = ST_FAULT;
          end else begin
            done_d    = !(aborted_q || abort);
            aborted_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (abort) begin
          aborted_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          code_d  = FC_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (unexpected) begin
      code_d  = FC_UNEXPECTED;
      state_d = ST_FAULT;
      done_d  = 1'b0;
    end
    if (abort || state_d == ST_FAULT || state_q == ST_FAULT) pend_d = 2'b00;
  end

  assign restart = (state_d != state_q);

  always_comb begin
    case (state_d)
      ST_ENERGIZE: load_us = US_W'(CONFIRM_US);
      ST_HOLD:     load_us = US_W'(HOLD_US);
      ST_COOLDOWN: load_us = US_W'(COOL_US);
      default:     load_us = '0;
    endcase
  end

  us_timer #(.TICK_DIV(TICK_DIV)) u_us_timer (
    .clk_i     (clk_100m),
    .rst_i     (rst),
    .restart_i (restart),
    .load_us_i (load_us),
    .expire_o  (expire)
  );

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= FC_NONE;
      pend_q    <= 2'b00;
      grant_q   <= 1'b0;
      aborted_q <= 1'b0;
      unexp_q   <= 2'b00;
      open_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      aborted_q <= aborted_d;
      unexp_q   <= unexp_now;
      open_q    <= (state_d == ST_ENERGIZE || state_d == ST_HOLD)
                   ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign right_drape_em_open = open_q[1];
  assign left_drape_em_open  = open_q[0];
  assign busy                = busy_q;
  assign grant_right         = grant_q;
  assign done                = done_q;
  assign fault               = fault_q;
  assign fault_code          = code_q;

endmodule

// File: tb/tb_drape_em_sequencer.sv
// Directed bench for drape_em_sequencer with TICK_DIV=4, CONFIRM_US=3, HOLD_US=5, COOL_US=2.
module tb_drape_em_sequencer;

  logic       clk_100m = 1'b0;
  logic       rst = 1'b1;
  logic       req_right = 1'b0, req_left = 1'b0, abort = 1'b0, fault_clr = 1'b0;
  logic       right_em = 1'b0, left_em = 1'b0;
  logic       right_open, left_open, busy, grant_right, done, fault;
  logic [1:0] fault_code;

  int errors = 0;
  int checks = 0;
  bit overlap_seen = 1'b0;

  drape_em_sequencer #(
    .TICK_DIV(4), .CONFIRM_US(3), .HOLD_US(5), .COOL_US(2)
  ) dut (
    .clk_100m             (clk_100m),
    .rst                  (rst),
    .req_right            (req_right),
    .req_left             (req_left),
    .abort                (abort),
    .fault_clr            (fault_clr),
    .right_drape_em_state (right_em),
    .left_drape_em_state  (left_em),
    .right_drape_em_open  (right_open),
    .left_drape_em_open   (left_open),
    .busy                 (busy),
    .grant_right          (grant_right),
    .done                 (done),
    .fault                (fault),
    .fault_code           (fault_code)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic step();
    @(posedge clk_100m);
    #1;
    if (right_open && left_open) overlap_seen = 1'b1;
  endtask

  task automatic pulse_req(input logic r, input logic l);
    req_right = r;
    req_left  = l;
    step();
    req_right = 1'b0;
    req_left  = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
  endtask

  task automatic wait_open_low(input bit right_side, output int n);
    n = 0;
    while ((right_side ? right_open : left_open) && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_100m);
    #1;
    checks++; if ({right_open, left_open, busy, done, fault} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {right_open, left_open, busy, done, fault}); end
    checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_code: got %b expected 00", fault_code); end
    checks++; if (grant_right !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant_right); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_two_requests();
    int n;
    pulse_req(1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_latch_busy: got %b expected 0", busy); end
    step();
    checks++; if ({right_open, left_open} !== 2'b10) begin errors++; $display("FAIL both_first_right: got %b expected 10", {right_open, left_open}); end
    checks++; if (grant_right !== 1'b1) begin errors++; $display("FAIL both_grant_right: got %b expected 1", grant_right); end
    right_em = 1'b1;
    wait_open_low(1'b1, n);
    checks++; if (n !== 21) begin errors++; $display("FAIL both_right_hold: got %0d expected 21", n); end
    right_em = 1'b0;
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL both_right_done: got %0d expected 8", n); end
    checks++; if (left_open !== 1'b0) begin errors++; $display("FAIL both_left_early: got %b expected 0", left_open); end
    step();
    checks++; if ({left_open, grant_right} !== 2'b10) begin errors++; $display("FAIL both_left_after_done: got %b expected 10", {left_open, grant_right}); end
    left_em = 1'b1;
    wait_open_low(1'b0, n);
    checks++; if (n !== 21) begin errors++; $display("FAIL both_left_hold: got %0d expected 21", n); end
    left_em = 1'b0;
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL both_left_done: got %0d expected 8", n); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_idle: got %b expected 0", busy); end
    checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL both_overlap: got %b expected 0", overlap_seen); end
  endtask

  task automatic test_single_right();
    int n;
    pulse_req(1'b1, 1'b0);
    step();
    checks++; if ({right_open, grant_right} !== 2'b11) begin errors++; $display("FAIL single_rise: got %b expected 11", {right_open, grant_right}); end
    repeat (5) step();
    checks++; if ({right_open, busy} !== 2'b11) begin errors++; $display("FAIL single_energize: got %b expected 11", {right_open, busy}); end
    right_em = 1'b1;
    step();
    req_right = 1'b1;
    step();
    req_right = 1'b0;
    // 7 cycles high so far; 19 more gives the 6+20 total
    wait_open_low(1'b1, n);
    checks++; if (n !== 19) begin errors++; $display("FAIL single_open_width: got %0d expected 19", n); end
    right_em = 1'b0;
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL single_done_delay: got %0d expected 8", n); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
    repeat (3) step();
    checks++; if ({right_open, busy} !== 2'b00) begin errors++; $display("FAIL single_repeat_ignored: got %b expected 00", {right_open, busy}); end
  endtask

  task automatic test_round_robin();
    int n;
    pulse_req(1'b1, 1'b1);
    step();
    checks++; if ({right_open, left_open, grant_right} !== 3'b010) begin errors++; $display("FAIL rr_left_first: got %b expected 010", {right_open, left_open, grant_right}); end
    left_em = 1'b1;
    wait_open_low(1'b0, n);
    left_em = 1'b0;
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL rr_left_done: got %0d expected 8", n); end
    step();
    checks++; if ({right_open, grant_right} !== 2'b11) begin errors++; $display("FAIL rr_right_second: got %b expected 11", {right_open, grant_right}); end
    right_em = 1'b1;
    wait_open_low(1'b1, n);
    right_em = 1'b0;
    wait_done(n);
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", busy); end
  endtask

  task automatic test_no_confirm();
    int n;
    pulse_req(1'b0, 1'b1);
    step();
    checks++; if (left_open !== 1'b1) begin errors++; $display("FAIL nc_rise: got %b expected 1", left_open); end
    wait_open_low(1'b0, n);
    checks++; if (n !== 12) begin errors++; $display("FAIL nc_timeout: got %0d expected 12", n); end
    checks++; if ({fault, fault_code, busy} !== 4'b1011) begin errors++; $display("FAIL nc_fault: got %b expected 1011", {fault, fault_code, busy}); end
    pulse_req(1'b1, 1'b0);
    repeat (3) step();
    checks++; if ({right_open, fault} !== 2'b01) begin errors++; $display("FAIL nc_req_ignored: got %b expected 01", {right_open, fault}); end
    pulse_clr();
    checks++; if ({fault, fault_code, busy} !== 4'b0000) begin errors++; $display("FAIL nc_clear: got %b expected 0000", {fault, fault_code, busy}); end
    repeat (3) step();
    checks++; if ({right_open, busy} !== 2'b00) begin errors++; $display("FAIL nc_pending_cleared: got %b expected 00", {right_open, busy}); end
  endtask

  task automatic test_abort();
    int n;
    bit done_seen;
    pulse_req(1'b1, 1'b0);
    step();
    right_em = 1'b1;
    step();
    pulse_req(1'b0, 1'b1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    right_em = 1'b0;
    checks++; if ({right_open, busy} !== 2'b01) begin errors++; $display("FAIL abort_drop: got %b expected 01", {right_open, busy}); end
    n = 0;
    done_seen = 1'b0;
    while (busy && n < 50) begin
      step();
      n++;
      if (done) done_seen = 1'b1;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL abort_cooldown: got %0d expected 8", n); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done_seen); end
    repeat (3) step();
    checks++; if ({left_open, busy} !== 2'b00) begin errors++; $display("FAIL abort_pending_cleared: got %b expected 00", {left_open, busy}); end
    abort = 1'b1;
    pulse_req(1'b0, 1'b1);
    repeat (2) step();
    checks++; if ({left_open, busy} !== 2'b00) begin errors++; $display("FAIL abort_idle_block: got %b expected 00", {left_open, busy}); end
    abort = 1'b0;
    repeat (3) step();
    checks++; if ({left_open, busy} !== 2'b00) begin errors++; $display("FAIL abort_idle_cleared: got %b expected 00", {left_open, busy}); end
  endtask

  task automatic test_no_release();
    int n;
    pulse_req(1'b0, 1'b1);
    step();
    left_em = 1'b1;
    wait_open_low(1'b0, n);
    checks++; if (n !== 21) begin errors++; $display("FAIL nr_hold: got %0d expected 21", n); end
    n = 0;
    while (!fault && n < 50) begin
      step();
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL nr_fault_time: got %0d expected 8", n); end
    checks++; if (fault_code !== 2'b10) begin errors++; $display("FAIL nr_code: got %b expected 10", fault_code); end
    left_em = 1'b0;
    pulse_clr();
    checks++; if ({fault, fault_code} !== 3'b000) begin errors++; $display("FAIL nr_clear: got %b expected 000", {fault, fault_code}); end
  endtask

  task automatic test_unexpected();
    left_em = 1'b1;
    step();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL unexp_one_cycle: got %b expected 0", fault); end
    step();
    checks++; if ({fault, fault_code, busy} !== 4'b1111) begin errors++; $display("FAIL unexp_fault: got %b expected 1111", {fault, fault_code, busy}); end
    left_em = 1'b0;
    pulse_req(1'b1, 1'b0);
    repeat (3) step();
    checks++; if ({right_open, fault} !== 2'b01) begin errors++; $display("FAIL unexp_req_ignored: got %b expected 01", {right_open, fault}); end
    pulse_clr();
    checks++; if ({fault, fault_code} !== 3'b000) begin errors++; $display("FAIL unexp_clear: got %b expected 000", {fault, fault_code}); end
    repeat (3) step();
    checks++; if ({right_open, busy} !== 2'b00) begin errors++; $display("FAIL unexp_idle: got %b expected 00", {right_open, busy}); end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_req(1'b1, 1'b0);
    step();
    step();
    checks++; if (right_open !== 1'b1) begin errors++; $display("FAIL rstmid_energize: got %b expected 1", right_open); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({right_open, left_open, busy, grant_right} !== 4'b0000) begin errors++; $display("FAIL rstmid_async: got %b expected 0000", {right_open, left_open, busy, grant_right}); end
    #3 rst = 1'b0;
    pulse_req(1'b0, 1'b1);
    step();
    checks++; if ({right_open, left_open, grant_right} !== 3'b010) begin errors++; $display("FAIL rstmid_left_grant: got %b expected 010", {right_open, left_open, grant_right}); end
    left_em = 1'b1;
    wait_open_low(1'b0, n);
    left_em = 1'b0;
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL rstmid_done: got %0d expected 8", n); end
  endtask

  initial begin
    test_reset();
    test_two_requests();
    test_single_right();
    test_round_robin();
    test_no_confirm();
    test_abort();
    test_no_release();
    test_unexpected();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/drape_em_sequencer.md
DRAPE_EM_SEQUENCER -- requirements
Module: drape_em_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, meaning clk_100m cycles per 1 us timer tick.
REQ-002 SHALL have parameter CONFIRM_US, default 100000, meaning max us from EM drive to em_state=1.
REQ-003 SHALL have parameter HOLD_US, default 500000, meaning us the EM stays driven after confirm.
REQ-004 SHALL have parameter COOL_US, default 200000, meaning us of mandatory off-time between grants.
REQ-005 SHALL have port clk_100m, in, 1, the single system clock.
REQ-006 SHALL have port rst, in, 1, a reset that is asynchronous and active-high.
REQ-007 SHALL have ports req_right and req_left, in, 1 each, single-cycle open-request pulses from the register block.
REQ-008 SHALL have port abort, in, 1, estop/cancel level.
REQ-009 SHALL have port fault_clr, in, 1, single-cycle fault-clear pulse.
REQ-010 SHALL have ports right_drape_em_state and left_drape_em_state, in, 1 each, with 1 meaning EM open, pre-synchronised.
REQ-011 SHALL have ports right_drape_em_open and left_drape_em_open, out, 1 each, the EM drive.
REQ-012 SHALL have ports busy (out, 1), grant_right (out, 1; 1=right, 0=left), done (out, 1, pulse), fault (out, 1, sticky) and fault_code (out, 2).

Function
REQ-013 SHALL implement FSM states IDLE, ENERGIZE, HOLD, COOLDOWN, FAULT.
REQ-014 SHALL latch each req_* pulse into a per-side pending bit; a repeat pulse while that side is pending or being served SHALL be ignored.
REQ-015 In IDLE with any pending bit set, the FSM SHALL go to ENERGIZE on the next edge and clear the served pending bit; if both are pending, round-robin SHALL apply (the side not last granted wins), with right winning first after reset.
REQ-016 The granted *_em_open output SHALL be registered and high exactly during ENERGIZE and HOLD, and SHALL never have both sides high.
REQ-017 Each timed state SHALL restart its 1 us prescaler on entry, so a state lasting N us lasts exactly N*TICK_DIV cycles.
REQ-018 In ENERGIZE, granted em_state=1 SHALL move to HOLD; reaching CONFIRM_US first SHALL go to FAULT with code 01.
REQ-019 HOLD SHALL last HOLD_US, then go to COOLDOWN.
REQ-020 COOLDOWN SHALL last COOL_US; if the granted em_state is still 1 at expiry, it SHALL go to FAULT with code 10; otherwise it SHALL go to IDLE and pulse done for 1 cycle (done SHALL NOT pulse if abort occurred).
REQ-021 em_state=1 on a side whose output is low for 2 consecutive cycles, in any non-FAULT state, SHALL go to FAULT with code 11.
REQ-022 abort high in ENERGIZE or HOLD SHALL drop outputs on the next edge, clear both pending bits and enter COOLDOWN; in IDLE, abort SHALL clear pending bits and block new grants while high.
REQ-023 FAULT SHALL force both outputs low, clear pending bits, ignore requests, and hold fault=1 with code until fault_clr, then go to IDLE (code 00).
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 If several fault causes occur in one cycle, priority SHALL be 11 > 01 > 10.

Reset
REQ-026 rst SHALL asynchronously force IDLE, both outputs 0, busy 0, done 0, fault 0, fault_code 00, pending 00, last grant = left (so right wins first), and the timer to 0.

Structure
REQ-027 SHALL place the state encoding and fault-code constants (NONE=00, NO_CONFIRM=01, NO_RELEASE=10, UNEXPECTED=11) in shared package rcb_drape_pkg.
REQ-028 SHALL use one sub-module, us_timer (prescaler + 20-bit us counter with restart and expiry), instantiated once.
REQ-029 The total RTL SHALL be 120-400 lines; all outputs SHALL be registered.

Verification (TICK_DIV=4, CONFIRM_US=3, HOLD_US=5, COOL_US=2)
REQ-030 Case 1: req_right, em_state rises 6 cycles later -> right open high for 6+20 cycles, then low; done pulses 8 cycles after drop; grant_right=1.
REQ-031 Case 2: req_right and req_left in the same cycle -> right served first, left granted on the cycle after done, never overlapping.
REQ-032 Case 3: req_left with no em_state -> open drops after 12 cycles; fault=1, code 01; fault_clr -> IDLE, fault=0.
REQ-033 Case 4: abort asserted mid-HOLD -> output low on the next edge, no done, pending left cleared, COOLDOWN 8 cycles, then IDLE.
REQ-034 Case 5: left_drape_em_state=1 for 2 cycles while IDLE -> fault code 11; requests ignored until fault_clr.
REQ-035 Case 6: rst asserted mid-ENERGIZE -> outputs 0 asynchronously; after release, the first req_left is granted normally.
